// File: rtl/regfile_wb.sv
// 32 x DATA_W register file with a one-entry registered write-back (pending) stage.
// Latency: write captured at edge N (forwarded to reads from then on), committed to the array at N+1.
// Backpressure: none; a write is accepted every cycle and the pending stage drains one per cycle.
module regfile_wb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              pend_valid,
  output logic              commit_valid,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [CNT_W-1:0]  commit_count
);

  // Register array; entry 0 is never written, so it stays at its reset value of zero.
  logic [DATA_W-1:0] regs [NREGS];

  // Pending write-back stage contents (valid bit is the pend_valid output).
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  // A pending write only reaches the array when it targets a nonzero register;
  // r0 writes ride through the pending stage and are silently dropped here.
  logic commit_en;
  assign commit_en = pend_valid && (pend_addr != '0);

  // Capture stage: valid follows wr_en every cycle, address/data hold when idle
  // so the last captured write stays observable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else begin
      pend_valid <= wr_en;
      if (wr_en) begin
        pend_addr <= wr_addr;
        pend_data <= wr_data;
      end
    end
  end

  // Commit stage: retire the pending write into the array. Reset clears the whole
  // array and, because the pending stage clears on the same edge, drops any
  // write still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit_en) begin
      regs[pend_addr] <= pend_data;
    end
  end

  // Commit status: one-cycle pulse, sticky last address, free-running wrapping count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      commit_valid <= 1'b0;
      commit_addr  <= '0;
      commit_count <= '0;
    end else begin
      commit_valid <= commit_en;
      if (commit_en) begin
        commit_addr  <= pend_addr;
        commit_count <= commit_count + CNT_W'(1);
      end
    end
  end

  // Read with forwarding: r0 is constant zero, the pending stage holds the newest
  // value for its address, otherwise the array is current. wr_data is deliberately
  // not bypassed; only captured writes are visible.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs[addr];
    if (addr == '0) begin
      val = '0;
    end else if (pend_valid && (pend_addr == addr)) begin
      val = pend_data;
    end
    return val;
  endfunction

  // Both ports resolve independently through the same priority.
  always_comb begin
    rd_data_a = read_port(rd_addr_a);
    rd_data_b = read_port(rd_addr_b);
  end

endmodule
